// File: rtl/ovb_split_if.sv
// ovb_split_if: write-side and 128-bit transmit-side signals of the output vector buffer.
interface ovb_split_if;
    logic         wen;
    logic         wlast;
    logic [255:0] wdata;
    logic         wready;
    logic         tvalid;
    logic         tready;
    logic         tleft;
    logic         tlast;
    logic [127:0] tdata;
    logic         busy;
    modport master (
        output wen, wlast, wdata, tready,
        input  wready, tvalid, tleft, tlast, tdata, busy
    );
    modport slave (
        input  wen, wlast, wdata, tready,
        output wready, tvalid, tleft, tlast, tdata, busy
    );
endinterface

// File: rtl/ovb_split.sv
// ovb_split: queues 256-bit vectors and emits each as two 128-bit beats, upper half first.
// Optional OVB_VEC_COUNT_EN adds a vec_count port counting vectors sent in the current stream.
module ovb_split #(
    parameter int DEPTH = 2
) (
    input logic clk,
    input logic reset,
    ovb_split_if.slave bus
`ifdef OVB_VEC_COUNT_EN
    ,
    output logic [15:0] vec_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;
    state_t state, state_nx;
    logic [AW:0] wptr, rptr;
    logic [256:0] mem [DEPTH];
    logic [255:0] hold;
    logic hlast;
    logic empty, full, push, pop;
    assign empty = wptr == rptr;
    assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push = bus.wen && !full;
    assign bus.wready = !full;
    // Popping in RIGHT on the accepted lower beat keeps vectors back to back.
    always_comb begin
        pop = !empty && (state == IDLE || (state == RIGHT && bus.tready));
        state_nx = state;
        if (pop)
            state_nx = LEFT;
        else if (state == LEFT && bus.tready)
            state_nx = RIGHT;
        else if (state == RIGHT && bus.tready)
            state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            wptr <= '0;
            rptr <= '0;
            hold <= '0;
            hlast <= 1'b0;
        end else begin
            state <= state_nx;
            if (push)
                wptr <= wptr + PTR_ONE;
            if (pop) begin
                rptr <= rptr + PTR_ONE;
                {hlast, hold} <= mem[rptr[AW-1:0]];
            end
        end
    end
    always_ff @(posedge clk)
        if (push)
            mem[wptr[AW-1:0]] <= {bus.wlast, bus.wdata};
    assign bus.tvalid = state != IDLE;
    assign bus.tleft = state == LEFT;
    assign bus.tlast = state == RIGHT && hlast;
    assign bus.tdata = bus.tleft ? hold[255:128] : hold[127:0];
    assign bus.busy = state != IDLE || !empty;
`ifdef OVB_VEC_COUNT_EN
    logic clr;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vec_count <= '0;
            clr <= 1'b0;
        end else begin
            clr <= bus.tvalid && bus.tready && bus.tlast;
            vec_count <= clr ? '0 : (bus.tvalid && bus.tready && !bus.tleft) ? vec_count + 16'd1 : vec_count;
        end
    end
`endif
endmodule

// File: tb/tb_ovb_split.sv
// tb_ovb_split: directed and random checks of ovb_split against a beat-queue reference model.
module tb_ovb_split;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    ovb_split_if bus();
`ifdef OVB_VEC_COUNT_EN
    logic [15:0] vec_count;
`endif
    ovb_split #(.DEPTH(2)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef OVB_VEC_COUNT_EN
        ,
        .vec_count(vec_count)
`endif
    );
    int errs = 0;
    int checks = 0;
    int nbeats = 0;
    logic [129:0] exp_q[$];
    logic mon_stall = 1'b0;
    logic [129:0] mon_prev = '0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [255:0] d, input logic l);
        bus.wen = 1'b1;
        bus.wdata = d;
        bus.wlast = l;
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Reference model: every accepted vector contributes an upper beat then a lower beat carrying its last flag.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            mon_stall <= 1'b0;
        end else begin
            if (mon_stall) begin
                chk("stall_valid", 256'(bus.tvalid), 256'(1));
                chk("stall_beat", 256'({bus.tleft, bus.tlast, bus.tdata}), 256'(mon_prev));
            end
            if (bus.tvalid && bus.tready) begin
                nbeats <= nbeats + 1;
                chk("sb_has_beat", 256'(exp_q.size() != 0), 256'(1));
                if (exp_q.size() != 0)
                    chk("sb_beat", 256'({bus.tleft, bus.tlast, bus.tdata}), 256'(exp_q.pop_front()));
            end
            if (bus.wen && bus.wready) begin
                exp_q.push_back({1'b1, 1'b0, bus.wdata[255:128]});
                exp_q.push_back({1'b0, bus.wlast, bus.wdata[127:0]});
            end
            mon_stall <= bus.tvalid && !bus.tready;
            mon_prev <= {bus.tleft, bus.tlast, bus.tdata};
        end
    end

    initial begin
        logic [255:0] v [3];
        logic [255:0] d;
        int n0;
        bus.wen = 1'b0;
        bus.wlast = 1'b0;
        bus.wdata = '0;
        bus.tready = 1'b0;
        repeat (3) step();
        chk("rst_tvalid", 256'(bus.tvalid), 256'(0));
        chk("rst_tleft", 256'(bus.tleft), 256'(0));
        chk("rst_tlast", 256'(bus.tlast), 256'(0));
        chk("rst_tdata", 256'(bus.tdata), 256'(0));
        chk("rst_busy", 256'(bus.busy), 256'(0));
        chk("rst_wready", 256'(bus.wready), 256'(1));
        reset = 1'b1;
        step();
        // single vector latency
        d = {{32{4'hA}}, {32{4'h5}}};
        wr(d, 1'b1);
        bus.tready = 1'b1;
        step();
        bus.wen = 1'b0;
        chk("one_n1_tvalid", 256'(bus.tvalid), 256'(0));
        chk("one_n1_busy", 256'(bus.busy), 256'(1));
        step();
        chk("one_hi_tvalid", 256'(bus.tvalid), 256'(1));
        chk("one_hi_tleft", 256'(bus.tleft), 256'(1));
        chk("one_hi_tdata", 256'(bus.tdata), 256'({32{4'hA}}));
        chk("one_hi_tlast", 256'(bus.tlast), 256'(0));
        step();
        chk("one_lo_tleft", 256'(bus.tleft), 256'(0));
        chk("one_lo_tdata", 256'(bus.tdata), 256'({32{4'h5}}));
        chk("one_lo_tlast", 256'(bus.tlast), 256'(1));
        step();
        chk("one_end_tvalid", 256'(bus.tvalid), 256'(0));
        chk("one_end_busy", 256'(bus.busy), 256'(0));
        // back to back, queue fills
        for (int i = 0; i < 3; i++) begin
            v[i] = rnd256();
            wr(v[i], i == 2);
            step();
        end
        bus.wen = 1'b0;
        chk("b2b_wready_full", 256'(bus.wready), 256'(0));
        chk("b2b_v0lo_tvalid", 256'(bus.tvalid), 256'(1));
        chk("b2b_v0lo_tleft", 256'(bus.tleft), 256'(0));
        chk("b2b_v0lo_tlast", 256'(bus.tlast), 256'(0));
        for (int i = 0; i < 4; i++) begin
            step();
            chk("b2b_tvalid", 256'(bus.tvalid), 256'(1));
            chk("b2b_tleft", 256'(bus.tleft), 256'(i % 2 == 0));
            chk("b2b_tdata", 256'(bus.tdata), 256'(i % 2 == 0 ? v[1 + i / 2][255:128] : v[1 + i / 2][127:0]));
            chk("b2b_tlast", 256'(bus.tlast), 256'(i == 3));
        end
        step();
        chk("b2b_end_tvalid", 256'(bus.tvalid), 256'(0));
        // backpressure in LEFT
        bus.tready = 1'b0;
        d = rnd256();
        wr(d, 1'b0);
        step();
        bus.wen = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_tvalid", 256'(bus.tvalid), 256'(1));
            chk("bp_tleft", 256'(bus.tleft), 256'(1));
            chk("bp_tdata", 256'(bus.tdata), 256'(d[255:128]));
            step();
        end
        bus.tready = 1'b1;
        chk("bp_rel_tleft", 256'(bus.tleft), 256'(1));
        step();
        chk("bp_right_tleft", 256'(bus.tleft), 256'(0));
        chk("bp_right_tdata", 256'(bus.tdata), 256'(d[127:0]));
        step();
        chk("bp_end_tvalid", 256'(bus.tvalid), 256'(0));
        // overflow drop
        bus.tready = 1'b0;
        n0 = nbeats;
        for (int i = 0; i < 3; i++) begin
            wr(rnd256(), 1'b0);
            step();
        end
        bus.wen = 1'b0;
        chk("ovf_wready", 256'(bus.wready), 256'(0));
        wr({16{16'hDEAD}}, 1'b1);
        step();
        step();
        bus.wen = 1'b0;
        chk("ovf_wready_hold", 256'(bus.wready), 256'(0));
        bus.tready = 1'b1;
        for (int i = 0; i < 20 && bus.busy; i++) step();
        chk("ovf_drain_busy", 256'(bus.busy), 256'(0));
        chk("ovf_beats", 256'(nbeats - n0), 256'(6));
        chk("ovf_sb_empty", 256'(exp_q.size()), 256'(0));
        // reset during RIGHT with two entries queued
        bus.tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr(rnd256(), 1'b1);
            step();
        end
        bus.wen = 1'b0;
        bus.tready = 1'b1;
        step();
        chk("rmid_in_right", 256'({bus.tvalid, bus.tleft, bus.wready}), 256'(3'b100));
        reset = 1'b0;
        #1;
        chk("rmid_tvalid", 256'(bus.tvalid), 256'(0));
        chk("rmid_busy", 256'(bus.busy), 256'(0));
        chk("rmid_wready", 256'(bus.wready), 256'(1));
        step();
        step();
        reset = 1'b1;
        n0 = nbeats;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rmid_post_tvalid", 256'(bus.tvalid), 256'(0));
        end
        chk("rmid_post_beats", 256'(nbeats - n0), 256'(0));
        // random traffic
        n0 = nbeats;
        for (int i = 0; i < 400; i++) begin
            bus.wen = $urandom_range(0, 2) != 0;
            bus.wdata = rnd256();
            bus.wlast = $urandom_range(0, 3) == 0;
            bus.tready = $urandom_range(0, 3) != 0;
            step();
        end
        bus.wen = 1'b0;
        bus.tready = 1'b1;
        for (int i = 0; i < 40 && bus.busy; i++) step();
        chk("rnd_drain_busy", 256'(bus.busy), 256'(0));
        chk("rnd_sb_empty", 256'(exp_q.size()), 256'(0));
        chk("rnd_some_beats", 256'(nbeats - n0 > 100), 256'(1));
`ifdef OVB_VEC_COUNT_EN
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("vc_reset", 256'(vec_count), 256'(0));
        for (int i = 0; i < 3; i++) begin
            wr(rnd256(), i == 2);
            step();
        end
        bus.wen = 1'b0;
        step();
        chk("vc_one", 256'(vec_count), 256'(1));
        step();
        step();
        chk("vc_two", 256'(vec_count), 256'(2));
        step();
        step();
        chk("vc_three", 256'(vec_count), 256'(3));
        step();
        chk("vc_clear", 256'(vec_count), 256'(0));
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
